// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the machine-mode trap sequencer.
//   - CSR numbers of the machine-mode registers touched by trap entry / mret
//   - mstatus bit positions
//   - sequencer FSM state encoding
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    T_EPC   = 4'd1,
    T_CAUSE = 4'd2,
    T_RSTAT = 4'd3,
    T_WSTAT = 4'd4,
    T_RTVEC = 4'd5,
    T_JUMP  = 4'd6,
    M_RSTAT = 4'd7,
    M_WSTAT = 4'd8,
    M_REPC  = 4'd9,
    M_JUMP  = 4'd10
  } seq_state_t;

endpackage

// File: rtl/csr_port_mux.sv
// csr_port_mux: combinational owner selection for the CSR file access port.
// Ports:
//   i_seq_en                    sequencer owns the port (busy, not in reset)
//   i_seq_we/re/addr/wdata      sequencer drive
//   i_core_gnt                  core access granted this cycle
//   i_core_we/addr/wdata        core drive
//   o_csr_addr/we/re/wdata      CSR file port (12-bit number zero-extended)
// When neither side owns the port every output is driven to zero.
module csr_port_mux #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              i_seq_en,
  input  logic              i_seq_we,
  input  logic              i_seq_re,
  input  logic [11:0]       i_seq_addr,
  input  logic [XLEN-1:0]   i_seq_wdata,
  input  logic              i_core_gnt,
  input  logic              i_core_we,
  input  logic [11:0]       i_core_addr,
  input  logic [XLEN-1:0]   i_core_wdata,
  output logic [ADDR_W-1:0] o_csr_addr,
  output logic              o_csr_we,
  output logic              o_csr_re,
  output logic [XLEN-1:0]   o_csr_wdata
);

  always_comb begin
    o_csr_addr  = '0;
    o_csr_we    = 1'b0;
    o_csr_re    = 1'b0;
    o_csr_wdata = '0;
    if (i_seq_en) begin
      o_csr_addr  = {{(ADDR_W-12){1'b0}}, i_seq_addr};
      o_csr_we    = i_seq_we;
      o_csr_re    = i_seq_re;
      o_csr_wdata = i_seq_wdata;
    end else if (i_core_gnt) begin
      o_csr_addr  = {{(ADDR_W-12){1'b0}}, i_core_addr};
      o_csr_we    = i_core_we;
      o_csr_re    = !i_core_we;
      o_csr_wdata = i_core_we ? i_core_wdata : '0;
    end
  end

endmodule

// File: rtl/csr_trap_sequencer.sv
// csr_trap_sequencer: owns the machine-mode CSR file port, runs trap entry and
// mret as fixed CSR bursts, arbitrates core CSR instructions against them and
// produces the fetch redirect (mtvec target on trap, mepc on mret).
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   trap_i/trap_pc_i/trap_cause_i     trap request (held until trap_ready_o)
//   trap_ready_o                      high only in IDLE
//   mret_i                            mret request, accepted in IDLE without trap_i
//   core_req_i/we_i/addr_i/wdata_i    core CSR access, core_gnt_o combinational
//   core_rdata_o/core_rvalid_o        read data, one cycle after a granted read
//   csr_addr_o/we_o/re_o/wdata_o      CSR file port, csr_rdata_i one cycle after re
//   csr_except_o                      high throughout the trap-entry states
//   redirect_valid_o/redirect_pc_o    one-cycle PC redirect pulse
// Build option: VECTORED_MODE_EN enables vectored mtvec for interrupts.
module csr_trap_sequencer
  import csr_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              trap_i,
  input  logic [XLEN-1:0]   trap_pc_i,
  input  logic [XLEN-1:0]   trap_cause_i,
  output logic              trap_ready_o,
  input  logic              mret_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [11:0]       core_addr_i,
  input  logic [XLEN-1:0]   core_wdata_i,
  output logic              core_gnt_o,
  output logic [XLEN-1:0]   core_rdata_o,
  output logic              core_rvalid_o,
  output logic [ADDR_W-1:0] csr_addr_o,
  output logic              csr_we_o,
  output logic              csr_re_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  input  logic [XLEN-1:0]   csr_rdata_i,
  output logic              csr_except_o,
  output logic              redirect_valid_o,
  output logic [XLEN-1:0]   redirect_pc_o
);

  seq_state_t      r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_cause;
  logic            r_rvalid;

  logic            w_idle;
  logic            w_seq_we;
  logic            w_seq_re;
  logic [11:0]     w_seq_addr;
  logic [XLEN-1:0] w_seq_wdata;
  logic [XLEN-1:0] w_status_trap;
  logic [XLEN-1:0] w_status_mret;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_target;

  assign w_idle = (r_state == IDLE);

  // Everything facing the outside is gated by rst_i so that a reset landing
  // mid-sequence suppresses the pending CSR write in that same cycle.
  assign trap_ready_o     = w_idle && !rst_i;
  assign core_gnt_o       = core_req_i && w_idle && !trap_i && !mret_i && !rst_i;
  assign core_rvalid_o    = r_rvalid;
  assign core_rdata_o     = r_rvalid ? csr_rdata_i : '0;
  assign csr_except_o     = !rst_i && (r_state inside {T_EPC, T_CAUSE, T_RSTAT,
                                                       T_WSTAT, T_RTVEC, T_JUMP});
  assign redirect_valid_o = !rst_i && (r_state inside {T_JUMP, M_JUMP});
  assign redirect_pc_o    = redirect_valid_o ? ((r_state == T_JUMP) ? w_target : w_base) : '0;

  always_comb begin
    w_status_trap                 = csr_rdata_i;
    w_status_trap[MSTATUS_MPIE]   = csr_rdata_i[MSTATUS_MIE];
    w_status_trap[MSTATUS_MIE]    = 1'b0;
    w_status_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

    w_status_mret                 = csr_rdata_i;
    w_status_mret[MSTATUS_MIE]    = csr_rdata_i[MSTATUS_MPIE];
    w_status_mret[MSTATUS_MPIE]   = 1'b1;
    w_status_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  assign w_base = {csr_rdata_i[XLEN-1:2], 2'b00};

`ifdef VECTORED_MODE_EN
  // 4*cause[XLEN-2:0] mod 2^XLEN: bit XLEN-2 shifts out of the word.
  assign w_target = (csr_rdata_i[1:0] == 2'b01 && r_cause[XLEN-1])
                  ? w_base + {r_cause[XLEN-3:0], 2'b00}
                  : w_base;
`else
  assign w_target = w_base;
`endif

  always_comb begin
    w_seq_we    = 1'b0;
    w_seq_re    = 1'b0;
    w_seq_addr  = '0;
    w_seq_wdata = '0;
    unique case (r_state)
      T_EPC:   begin w_seq_we = 1'b1; w_seq_addr = CSR_MEPC;    w_seq_wdata = r_pc;          end
      T_CAUSE: begin w_seq_we = 1'b1; w_seq_addr = CSR_MCAUSE;  w_seq_wdata = r_cause;       end
      T_RSTAT: begin w_seq_re = 1'b1; w_seq_addr = CSR_MSTATUS;                              end
      T_WSTAT: begin w_seq_we = 1'b1; w_seq_addr = CSR_MSTATUS; w_seq_wdata = w_status_trap; end
      T_RTVEC: begin w_seq_re = 1'b1; w_seq_addr = CSR_MTVEC;                                end
      M_RSTAT: begin w_seq_re = 1'b1; w_seq_addr = CSR_MSTATUS;                              end
      M_WSTAT: begin w_seq_we = 1'b1; w_seq_addr = CSR_MSTATUS; w_seq_wdata = w_status_mret; end
      M_REPC:  begin w_seq_re = 1'b1; w_seq_addr = CSR_MEPC;                                 end
      default: ;
    endcase
  end

  csr_port_mux #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W)
  ) u_port_mux (
    .i_seq_en     (!w_idle && !rst_i),
    .i_seq_we     (w_seq_we),
    .i_seq_re     (w_seq_re),
    .i_seq_addr   (w_seq_addr),
    .i_seq_wdata  (w_seq_wdata),
    .i_core_gnt   (core_gnt_o),
    .i_core_we    (core_we_i),
    .i_core_addr  (core_addr_i),
    .i_core_wdata (core_wdata_i),
    .o_csr_addr   (csr_addr_o),
    .o_csr_we     (csr_we_o),
    .o_csr_re     (csr_re_o),
    .o_csr_wdata  (csr_wdata_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_pc     <= '0;
      r_cause  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= core_gnt_o && !core_we_i;
      unique case (r_state)
        IDLE: begin
          if (trap_i) begin
            r_state <= T_EPC;
            r_pc    <= trap_pc_i;
            r_cause <= trap_cause_i;
          end else if (mret_i) begin
            r_state <= M_RSTAT;
          end
        end
        T_EPC:   r_state <= T_CAUSE;
        T_CAUSE: r_state <= T_RSTAT;
        T_RSTAT: r_state <= T_WSTAT;
        T_WSTAT: r_state <= T_RTVEC;
        T_RTVEC: r_state <= T_JUMP;
        T_JUMP:  r_state <= IDLE;
        M_RSTAT: r_state <= M_WSTAT;
        M_WSTAT: r_state <= M_REPC;
        M_REPC:  r_state <= M_JUMP;
        M_JUMP:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
module tb_csr_trap_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        trap_i;
  logic [31:0] trap_pc_i;
  logic [31:0] trap_cause_i;
  logic        trap_ready_o;
  logic        mret_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [11:0] core_addr_i;
  logic [31:0] core_wdata_i;
  logic        core_gnt_o;
  logic [31:0] core_rdata_o;
  logic        core_rvalid_o;
  logic [31:0] csr_addr_o;
  logic        csr_we_o;
  logic        csr_re_o;
  logic [31:0] csr_wdata_o;
  logic [31:0] csr_rdata_i;
  logic        csr_except_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;

  // Small CSR file model: writes on the clock, read data one cycle after re.
  logic        model_init;
  logic [31:0] m_mstatus, m_mepc, m_mcause, m_mtvec;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  csr_trap_sequencer #(.XLEN(32), .ADDR_W(32)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .trap_i           (trap_i),
    .trap_pc_i        (trap_pc_i),
    .trap_cause_i     (trap_cause_i),
    .trap_ready_o     (trap_ready_o),
    .mret_i           (mret_i),
    .core_req_i       (core_req_i),
    .core_we_i        (core_we_i),
    .core_addr_i      (core_addr_i),
    .core_wdata_i     (core_wdata_i),
    .core_gnt_o       (core_gnt_o),
    .core_rdata_o     (core_rdata_o),
    .core_rvalid_o    (core_rvalid_o),
    .csr_addr_o       (csr_addr_o),
    .csr_we_o         (csr_we_o),
    .csr_re_o         (csr_re_o),
    .csr_wdata_o      (csr_wdata_o),
    .csr_rdata_i      (csr_rdata_i),
    .csr_except_o     (csr_except_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o)
  );

  always @(posedge clk_i) begin
    if (model_init) begin
      m_mstatus   <= 32'h0000_0008;
      m_mepc      <= '0;
      m_mcause    <= '0;
      csr_rdata_i <= '0;
    end else begin
      if (csr_we_o) begin
        case (csr_addr_o)
          32'h300: m_mstatus <= csr_wdata_o;
          32'h341: m_mepc    <= csr_wdata_o;
          32'h342: m_mcause  <= csr_wdata_o;
          default: ;
        endcase
      end
      if (csr_re_o) begin
        case (csr_addr_o)
          32'h300: csr_rdata_i <= m_mstatus;
          32'h305: csr_rdata_i <= m_mtvec;
          32'h341: csr_rdata_i <= m_mepc;
          32'h342: csr_rdata_i <= m_mcause;
          default: csr_rdata_i <= '0;
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  logic [31:0] exp_vec;
  logic [31:0] saved_status;
  int          cyc;

  initial begin
    rst_i = 1'b1; model_init = 1'b1;
    trap_i = 1'b0; trap_pc_i = '0; trap_cause_i = '0; mret_i = 1'b0;
    core_req_i = 1'b0; core_we_i = 1'b0; core_addr_i = '0; core_wdata_i = '0;
    m_mtvec = 32'h0000_0200;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0; model_init = 1'b0;
    #1;
    chk("rst_ready",    {31'b0, trap_ready_o},     32'd1);
    chk("rst_redir",    {31'b0, redirect_valid_o}, 32'd0);
    chk("rst_we",       {31'b0, csr_we_o},         32'd0);
    chk("rst_re",       {31'b0, csr_re_o},         32'd0);
    chk("rst_except",   {31'b0, csr_except_o},     32'd0);
    chk("rst_rvalid",   {31'b0, core_rvalid_o},    32'd0);

    // Trap: pc 0x1000, cause 2, mstatus 0x8, mtvec 0x200
    trap_i = 1'b1; trap_pc_i = 32'h0000_1000; trap_cause_i = 32'h2;
    step(); trap_i = 1'b0;
    chk("t1_ready",  {31'b0, trap_ready_o}, 32'd0);
    chk("t1_we",     {31'b0, csr_we_o},     32'd1);
    chk("t1_addr",   csr_addr_o,            32'h341);
    chk("t1_wdata",  csr_wdata_o,           32'h1000);
    chk("t1_exc",    {31'b0, csr_except_o}, 32'd1);
    step();
    chk("t2_addr",   csr_addr_o,            32'h342);
    chk("t2_wdata",  csr_wdata_o,           32'h2);
    step();
    chk("t3_re",     {31'b0, csr_re_o},     32'd1);
    chk("t3_we",     {31'b0, csr_we_o},     32'd0);
    chk("t3_addr",   csr_addr_o,            32'h300);
    step();
    chk("t4_we",     {31'b0, csr_we_o},     32'd1);
    chk("t4_wdata",  csr_wdata_o,           32'h1880);
    step();
    chk("t5_re",     {31'b0, csr_re_o},     32'd1);
    chk("t5_addr",   csr_addr_o,            32'h305);
    step();
    chk("t6_redir",  {31'b0, redirect_valid_o}, 32'd1);
    chk("t6_pc",     redirect_pc_o,             32'h200);
    chk("t6_nowe",   {30'b0, csr_we_o, csr_re_o}, 32'd0);
    step();
    chk("t7_redir",  {31'b0, redirect_valid_o}, 32'd0);
    chk("t7_ready",  {31'b0, trap_ready_o},     32'd1);
    chk("t_mepc",    m_mepc,    32'h1000);
    chk("t_mcause",  m_mcause,  32'h2);
    chk("t_mstatus", m_mstatus, 32'h1880);

    // mret
    mret_i = 1'b1;
    step(); mret_i = 1'b0;
    chk("m1_re",     {31'b0, csr_re_o},     32'd1);
    chk("m1_addr",   csr_addr_o,            32'h300);
    chk("m1_exc",    {31'b0, csr_except_o}, 32'd0);
    step();
    chk("m2_we",     {31'b0, csr_we_o},     32'd1);
    chk("m2_wdata",  csr_wdata_o,           32'h1888);
    step();
    chk("m3_addr",   csr_addr_o,            32'h341);
    step();
    chk("m4_redir",  {31'b0, redirect_valid_o}, 32'd1);
    chk("m4_pc",     redirect_pc_o,             32'h1000);
    step();
    chk("m5_redir",  {31'b0, redirect_valid_o}, 32'd0);
    chk("m_mstatus", m_mstatus, 32'h1888);

    // Vectored-mode interrupt trap
    m_mtvec = 32'h0000_0201;
`ifdef VECTORED_MODE_EN
    exp_vec = 32'h0000_021C;
`else
    exp_vec = 32'h0000_0200;
`endif
    trap_i = 1'b1; trap_pc_i = 32'h0000_2000; trap_cause_i = 32'h8000_0007;
    step(); trap_i = 1'b0;
    cyc = 1;
    while (!redirect_valid_o && cyc < 20) begin
      step(); cyc++;
    end
    chk("v_cycle", cyc, 32'd6);
    chk("v_pc",    redirect_pc_o, exp_vec);
    step();

    // Core read of mtvec held against a simultaneous trap
    m_mtvec = 32'h0000_0200;
    trap_i = 1'b1; trap_pc_i = 32'h0000_3000; trap_cause_i = 32'h5;
    core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 12'h305;
    #1;
    chk("a0_gnt", {31'b0, core_gnt_o}, 32'd0);
    step(); trap_i = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      chk("a_busy_gnt", {31'b0, core_gnt_o}, 32'd0);
      step();
    end
    chk("a7_gnt",  {31'b0, core_gnt_o}, 32'd1);
    chk("a7_re",   {31'b0, csr_re_o},   32'd1);
    chk("a7_addr", csr_addr_o,          32'h305);
    chk("a7_rv",   {31'b0, core_rvalid_o}, 32'd0);
    step(); core_req_i = 1'b0;
    chk("a8_rv",    {31'b0, core_rvalid_o}, 32'd1);
    chk("a8_rdata", core_rdata_o,           32'h200);
    step();
    chk("a9_rv",    {31'b0, core_rvalid_o}, 32'd0);

    // trap_i and mret_i together: trap only
    trap_i = 1'b1; mret_i = 1'b1; trap_pc_i = 32'h0000_4000; trap_cause_i = 32'h3;
    step(); trap_i = 1'b0; mret_i = 1'b0;
    chk("b1_addr", csr_addr_o,            32'h341);
    chk("b1_exc",  {31'b0, csr_except_o}, 32'd1);
    repeat (5) step();
    chk("b6_pc",   redirect_pc_o,         32'h200);
    step();
    chk("b7_ready", {31'b0, trap_ready_o},     32'd1);
    chk("b7_idle",  {30'b0, csr_we_o, csr_re_o}, 32'd0);
    chk("b_mepc",   m_mepc,                    32'h4000);

    // Reset landing in T_WSTAT
    saved_status = m_mstatus;
    trap_i = 1'b1; trap_pc_i = 32'h0000_5000; trap_cause_i = 32'h4;
    step(); trap_i = 1'b0;
    repeat (3) step();
    chk("r4_we_pre", {31'b0, csr_we_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("r4_we_rst", {31'b0, csr_we_o}, 32'd0);
    step(); rst_i = 1'b0;
    #1;
    chk("r5_ready",  {31'b0, trap_ready_o},     32'd1);
    chk("r5_exc",    {31'b0, csr_except_o},     32'd0);
    chk("r5_redir",  {31'b0, redirect_valid_o}, 32'd0);
    chk("r5_port",   {30'b0, csr_we_o, csr_re_o}, 32'd0);
    chk("r5_status", m_mstatus, saved_status);
    step();
    chk("r6_port",   {30'b0, csr_we_o, csr_re_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
